reg_universal: RTL and testbench
================================

REG_UNIVERSAL -- requirements
Module: reg_universal

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width in bits; legal range 2..64.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port set  input  1  synchronous active-high set, forcing all Q bits to 1.
REQ-005 SHALL have port mode  input  3  operation select (encodings in REQ-010).
REQ-006 SHALL have port D  input  WIDTH  parallel load data.
REQ-007 SHALL have port sil  input  1  serial input for shift-left; it enters Q[0].
REQ-008 SHALL have port sir  input  1  serial input for shift-right; it enters Q[WIDTH-1].
REQ-009 SHALL have outputs: Q  output  WIDTH  register contents; carry  output  1  registered shift-out/wrap flag; zero  output  1  combinational, high when Q == 0.

Function
REQ-010 SHALL decode mode as follows: 000 hold; 001 load Q<=D; 010 shl Q<={Q[W-2:0],sil}; 011 shr Q<={sir,Q[W-1:1]}; 100 rotl; 101 rotr; 110 inc Q<=Q+1; 111 dec Q<=Q-1.
REQ-011 SHALL apply update priority per edge: reset > set > mode.
REQ-012 SHALL give Q and carry a latency of exactly one clk edge from the inputs sampled on that edge.
REQ-013 SHALL set carry on shl/rotl to the old Q[WIDTH-1], and on shr/rotr to the old Q[0].
REQ-014 SHALL set carry on inc to 1 only when old Q is all-ones; the result wraps to 0.
REQ-015 SHALL set carry on dec to 1 only when old Q is 0; the result wraps to all-ones.
REQ-016 SHALL hold carry on mode hold and clear it to 0 on load, set and reset.
REQ-017 SHALL keep the count arithmetic modulo 2^WIDTH, with no intermediate width exceeding WIDTH+1.
REQ-018 SHALL derive zero combinationally from the current Q, with no registered delay.

Reset
REQ-019 SHALL clear Q to 0 and carry to 0 on any clk edge with reset=1, regardless of set and mode.
REQ-020 SHALL let reset abort an operation mid-sequence with no residual state; the next edge behaves as from power-on.
REQ-021 SHALL, on an edge with set=1 and reset=0, drive Q to all-ones and carry to 0, ignoring mode.

Configuration
REQ-022 SHALL compile in count modes 110/111 when macro REG_UNIVERSAL_COUNT_EN is defined, behaving per REQ-014/015.
REQ-023 SHALL, when REG_UNIVERSAL_COUNT_EN is undefined, treat modes 110/111 as hold (Q and carry unchanged) and build no incrementer or decrementer logic.

Structure
REQ-024 SHALL place the mode encodings (MODE_HOLD..MODE_DEC as 3-bit constants) in shared package reg_pkg; the core and the bench SHALL both use these constants.
REQ-025 SHALL instantiate the existing dff_sync_set_reset cell once per Q bit, with a combinational next-state mux per bit; carry SHALL be its own dff_sync_set_reset with set tied 0.
REQ-026 SHALL contain no other sub-modules and no latches.

Verification (WIDTH=8)
REQ-027 SHALL verify: reset=1, set=1, mode=001, D=0x5A -> next edge Q=0x00, carry=0, zero=1.
REQ-028 SHALL verify: load 0xA5, then shl with sil=1 -> Q=0x4B, carry=1; then shr with sir=0 -> Q=0x25, carry=1.
REQ-029 SHALL verify: load 0x01, then rotr -> Q=0x80, carry=1; then rotl -> Q=0x01, carry=1.
REQ-030 SHALL verify, with macro defined: load 0xFF, inc -> Q=0x00, carry=1, zero=1; then dec -> Q=0xFF, carry=1.
REQ-031 SHALL verify, with macro undefined: load 0xFF, mode=110 -> Q=0xFF, carry=0 (held from load).
REQ-032 SHALL verify: load 0x3C, set=1 with mode=010 -> Q=0xFF, carry=0; 3 hold cycles -> Q stays 0xFF.

Source files
------------

// File: rtl/reg_pkg.sv
// -----------------------------------------------------------------------------
// reg_pkg
// Shared constants for the universal register. The core and its bench both use
// these 3-bit mode encodings, so neither side has a private copy to drift.
// No ports.
// -----------------------------------------------------------------------------
package reg_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROTL = 3'b100;
    localparam logic [2:0] MODE_ROTR = 3'b101;
    localparam logic [2:0] MODE_INC  = 3'b110;
    localparam logic [2:0] MODE_DEC  = 3'b111;

endpackage

// File: rtl/dff_sync_set_reset.sv
// -----------------------------------------------------------------------------
// dff_sync_set_reset
// Single-bit D flip-flop with synchronous reset and set. Reset wins over set,
// and set wins over d.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high clear (q <= 0)
//   set   - synchronous active-high preset (q <= 1)
//   d     - next-state data
//   q     - registered output
// -----------------------------------------------------------------------------
module dff_sync_set_reset (
    input  logic clk,
    input  logic reset,
    input  logic set,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= 1'b0;
        end else if (set) begin
            q <= 1'b1;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_universal.sv
// -----------------------------------------------------------------------------
// reg_universal
// Universal register: hold, parallel load, shift left/right with serial input,
// rotate left/right, and optionally increment/decrement. Every state bit is a
// dff_sync_set_reset cell fed by a combinational next-state mux.
//
// Optional feature: define REG_UNIVERSAL_COUNT_EN to build the count modes
// (110 inc, 111 dec). Without it those modes behave as hold and no adder or
// subtractor exists.
//
// Parameters:
//   WIDTH - register width in bits (2..64)
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high clear of Q and carry (highest priority)
//   set   - synchronous active-high preset of Q to all-ones, clears carry
//   mode  - operation select, encodings in reg_pkg
//   D     - parallel load data
//   sil   - serial input shifted into Q[0] on shift-left
//   sir   - serial input shifted into Q[WIDTH-1] on shift-right
//   Q     - register contents
//   carry - registered shift-out / wrap flag
//   zero  - combinational, high when Q == 0
// -----------------------------------------------------------------------------
module reg_universal
    import reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] D,
    input  logic             sil,
    input  logic             sir,
    output logic [WIDTH-1:0] Q,
    output logic             carry,
    output logic             zero
);

    logic [WIDTH-1:0] next_q;
    logic             next_c;

`ifdef REG_UNIVERSAL_COUNT_EN
    // One extra bit holds the carry-out of the increment and the borrow of
    // the decrement; the low WIDTH bits wrap modulo 2^WIDTH on their own.
    localparam logic [WIDTH:0] ONE_EXT = (WIDTH+1)'(1);
    logic [WIDTH:0] inc_sum;
    logic [WIDTH:0] dec_diff;

    assign inc_sum  = {1'b0, Q} + ONE_EXT;
    assign dec_diff = {1'b0, Q} - ONE_EXT;
`endif

    // Next-state mux. Reset is handled inside the cells; set forces Q via the
    // cell's set pin, so only carry needs explicit clearing here.
    always_comb begin
        next_q = Q;
        next_c = carry;
        case (mode)
            MODE_HOLD: begin
                next_q = Q;
                next_c = carry;
            end
            MODE_LOAD: begin
                next_q = D;
                next_c = 1'b0;
            end
            MODE_SHL: begin
                next_q = {Q[WIDTH-2:0], sil};
                next_c = Q[WIDTH-1];
            end
            MODE_SHR: begin
                next_q = {sir, Q[WIDTH-1:1]};
                next_c = Q[0];
            end
            MODE_ROTL: begin
                next_q = {Q[WIDTH-2:0], Q[WIDTH-1]};
                next_c = Q[WIDTH-1];
            end
            MODE_ROTR: begin
                next_q = {Q[0], Q[WIDTH-1:1]};
                next_c = Q[0];
            end
`ifdef REG_UNIVERSAL_COUNT_EN
            MODE_INC: begin
                next_q = inc_sum[WIDTH-1:0];
                next_c = inc_sum[WIDTH];
            end
            MODE_DEC: begin
                next_q = dec_diff[WIDTH-1:0];
                next_c = dec_diff[WIDTH];
            end
`endif
            default: begin
                next_q = Q;
                next_c = carry;
            end
        endcase
        if (set) begin
            next_c = 1'b0;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dff_sync_set_reset u_q (
            .clk   (clk),
            .reset (reset),
            .set   (set),
            .d     (next_q[i]),
            .q     (Q[i])
        );
    end

    dff_sync_set_reset u_carry (
        .clk   (clk),
        .reset (reset),
        .set   (1'b0),
        .d     (next_c),
        .q     (carry)
    );

    assign zero = (Q == '0);

endmodule

// File: tb/tb_reg_universal.sv
// -----------------------------------------------------------------------------
// tb_reg_universal
// Self-checking bench for reg_universal (WIDTH=8). A behavioural model tracks
// the register as an integer and is compared with the DUT on every falling
// edge; directed literal checks pin the model to hand-computed values.
// Honours REG_UNIVERSAL_COUNT_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_reg_universal;
    import reg_pkg::*;

    localparam int W = 8;
    localparam longint M = 256;

    // clock / reset block
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         set = 1'b0;
    logic [2:0]   mode = MODE_HOLD;
    logic [W-1:0] D = '0;
    logic         sil = 1'b0;
    logic         sir = 1'b0;
    logic [W-1:0] Q;
    logic         carry;
    logic         zero;

    always #5 clk = ~clk;

    reg_universal #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .set   (set),
        .mode  (mode),
        .D     (D),
        .sil   (sil),
        .sir   (sir),
        .Q     (Q),
        .carry (carry),
        .zero  (zero)
    );

    int pass_cnt = 0;
    int total_cnt = 0;
    bit checking = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: register value as an integer modulo 2^W.
    longint m_q = 0;
    logic   m_c = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_q <= 0;
            m_c <= 1'b0;
        end else if (set) begin
            m_q <= M - 1;
            m_c <= 1'b0;
        end else begin
            case (mode)
                MODE_LOAD: begin
                    m_q <= longint'(D);
                    m_c <= 1'b0;
                end
                MODE_SHL: begin
                    m_q <= (m_q * 2 + longint'(sil)) % M;
                    m_c <= (m_q >= M / 2);
                end
                MODE_SHR: begin
                    m_q <= m_q / 2 + longint'(sir) * (M / 2);
                    m_c <= (m_q % 2 == 1);
                end
                MODE_ROTL: begin
                    m_q <= (m_q * 2) % M + m_q / (M / 2);
                    m_c <= (m_q >= M / 2);
                end
                MODE_ROTR: begin
                    m_q <= m_q / 2 + (m_q % 2) * (M / 2);
                    m_c <= (m_q % 2 == 1);
                end
`ifdef REG_UNIVERSAL_COUNT_EN
                MODE_INC: begin
                    m_q <= (m_q + 1) % M;
                    m_c <= (m_q == M - 1);
                end
                MODE_DEC: begin
                    m_q <= (m_q + M - 1) % M;
                    m_c <= (m_q == 0);
                end
`endif
                default: begin
                    m_q <= m_q;
                    m_c <= m_c;
                end
            endcase
        end
    end

    // scoreboard compare process: every cycle once the first reset has landed
    always @(negedge clk) begin
        if (checking) begin
            check("model_q", 64'(Q), 64'(m_q));
            check("model_carry", 64'(carry), 64'(m_c));
            check("model_zero", 64'(zero), 64'(m_q == 0));
        end
    end

    // driver task: apply inputs, let one rising edge take them, return at negedge
    task automatic step(input logic r, input logic s, input logic [2:0] m,
                        input logic [W-1:0] d, input logic l, input logic rr);
        reset = r;
        set   = s;
        mode  = m;
        D     = d;
        sil   = l;
        sir   = rr;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic op(input logic [2:0] m, input logic [W-1:0] d);
        step(1'b0, 1'b0, m, d, 1'b0, 1'b0);
    endtask

    logic [W-1:0] d_tab [4];

    initial begin
        d_tab[0] = 8'h00;
        d_tab[1] = 8'h81;
        d_tab[2] = 8'hFF;
        d_tab[3] = 8'h6E;

        // reset dominates set and load
        step(1'b1, 1'b1, MODE_LOAD, 8'h5A, 1'b0, 1'b0);
        checking = 1'b1;
        check("reset_q", 64'(Q), 64'h00);
        check("reset_carry", 64'(carry), 64'h0);
        check("reset_zero", 64'(zero), 64'h1);

        // shift left then right
        op(MODE_LOAD, 8'hA5);
        step(1'b0, 1'b0, MODE_SHL, 8'h00, 1'b1, 1'b0);
        check("shl_q", 64'(Q), 64'h4B);
        check("shl_carry", 64'(carry), 64'h1);
        step(1'b0, 1'b0, MODE_SHR, 8'h00, 1'b0, 1'b0);
        check("shr_q", 64'(Q), 64'h25);
        check("shr_carry", 64'(carry), 64'h1);

        // rotates
        op(MODE_LOAD, 8'h01);
        op(MODE_ROTR, 8'h00);
        check("rotr_q", 64'(Q), 64'h80);
        check("rotr_carry", 64'(carry), 64'h1);
        op(MODE_ROTL, 8'h00);
        check("rotl_q", 64'(Q), 64'h01);
        check("rotl_carry", 64'(carry), 64'h1);

        // count modes, or their absence
        op(MODE_LOAD, 8'hFF);
        op(MODE_INC, 8'h00);
`ifdef REG_UNIVERSAL_COUNT_EN
        check("inc_wrap_q", 64'(Q), 64'h00);
        check("inc_wrap_carry", 64'(carry), 64'h1);
        check("inc_wrap_zero", 64'(zero), 64'h1);
        op(MODE_DEC, 8'h00);
        check("dec_wrap_q", 64'(Q), 64'hFF);
        check("dec_wrap_carry", 64'(carry), 64'h1);
        op(MODE_LOAD, 8'h7F);
        op(MODE_INC, 8'h00);
        check("inc_plain_q", 64'(Q), 64'h80);
        check("inc_plain_carry", 64'(carry), 64'h0);
`else
        check("inc_off_q", 64'(Q), 64'hFF);
        check("inc_off_carry", 64'(carry), 64'h0);
        op(MODE_DEC, 8'h00);
        check("dec_off_q", 64'(Q), 64'hFF);
`endif

        // set overrides mode, then hold keeps all-ones
        op(MODE_LOAD, 8'h3C);
        step(1'b0, 1'b1, MODE_SHL, 8'h00, 1'b1, 1'b0);
        check("set_q", 64'(Q), 64'hFF);
        check("set_carry", 64'(carry), 64'h0);
        for (int i = 0; i < 3; i++) begin
            op(MODE_HOLD, 8'h00);
            check("set_hold_q", 64'(Q), 64'hFF);
        end

        // hold keeps a set carry
        op(MODE_LOAD, 8'h80);
        op(MODE_SHL, 8'h00);
        check("shl_out_zero", 64'(zero), 64'h1);
        op(MODE_HOLD, 8'h00);
        check("hold_carry", 64'(carry), 64'h1);

        // reset mid-sequence, next edge behaves from a clean state
        op(MODE_LOAD, 8'hC3);
        step(1'b1, 1'b0, MODE_ROTL, 8'h00, 1'b0, 1'b0);
        check("abort_q", 64'(Q), 64'h00);
        check("abort_carry", 64'(carry), 64'h0);
        op(MODE_SHR, 8'h00);
        check("after_abort_q", 64'(Q), 64'h00);
        check("after_abort_carry", 64'(carry), 64'h0);

        // sweep every mode from a few loaded values; the model checks each cycle
        foreach (d_tab[k]) begin
            for (int m = 0; m < 8; m++) begin
                op(MODE_LOAD, d_tab[k]);
                step(1'b0, 1'b0, 3'(m), ~d_tab[k], k[0], k[1]);
            end
        end

        step(1'b0, 1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0);
        checking = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
